// File: rtl/axi_sram_responder.sv
// ----------------------------------------------------------------------------
// axi_sram_responder
//
// AXI3 slave in front of a 32-bit synchronous word RAM. It serves icache and
// dcache burst reads and uncached writes, and doubles as the on-chip boot SRAM.
// The read and write channels are independent. Each channel has at most one
// burst in flight.
//
// Optional feature: define AXI_SRAM_WRAP_EN to enable WRAP bursts (burst=2'b10).
// A WRAP burst stays inside a (len+1)*4-byte aligned window. If len is not
// 1/3/7/15, the whole burst answers SLVERR. When the macro is undefined, WRAP
// bursts behave as INCR bursts.
//
// Handshake rule: a transfer happens on a rising edge where valid && ready.
// valid and the payload stay stable until that edge. ready never depends
// combinationally on valid.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   ar* / r*                     read address and read data channels
//   aw* / w* / b*                write address, write data and write response channels
//   arsize..awprot, wid          accepted but ignored; every beat is 4 bytes
//   dbg_r_state, dbg_w_state     current read / write FSM state
// ----------------------------------------------------------------------------
module axi_sram_responder #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  dbg_r_state,
    output logic [1:0]  dbg_w_state
);

`ifdef AXI_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_BURST = 2'd1} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    logic unused_inputs;
    assign unused_inputs = ^{arsize, awsize, arlock, awlock, arcache, awcache, arprot, awprot, wid};

    function automatic logic in_range(input logic [31:0] a);
        in_range = (a[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
    endfunction

    function automatic logic len_ok(input logic [7:0] len);
        len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // WRAP keeps the bits above the window and increments only inside it.
    // INCR simply adds 4, so a burst can run past the top of the RAM into
    // out-of-range space.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len, input logic wrap);
        logic [31:0] mask;
        logic [31:0] inc;
        mask = {22'd0, len, 2'b11};
        inc  = a + 32'd4;
        next_addr = wrap ? ((a & ~mask) | (inc & mask)) : inc;
    endfunction

    // ---------------- read channel ----------------
    r_state_e    r_state_q, r_state_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d, raddr_q, raddr_d, rd_addr;
    logic [1:0]  rresp_q, rresp_d;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic        rwrap_q, rwrap_d, rbad_q, rbad_d, rd_fetch, rd_bad;

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rwrap_d   = rwrap_q;
        rbad_d    = rbad_q;
        rd_fetch  = 1'b0;
        rd_addr   = raddr_q;
        rd_bad    = rbad_q;
        case (r_state_q)
            R_IDLE: if (arvalid) begin
                r_state_d = R_BURST;
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
                rid_d     = arid;
                raddr_d   = araddr;
                rlen_d    = arlen;
                rcnt_d    = 8'd0;
                rwrap_d   = WRAP_EN && (arburst == 2'b10);
                rbad_d    = rwrap_d && !len_ok(arlen);
                rlast_d   = (arlen == 8'd0);
                rd_fetch  = 1'b1;
                rd_addr   = araddr;
                rd_bad    = rbad_d;
            end
            R_BURST: if (rready) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                end else begin
                    raddr_d  = next_addr(raddr_q, rlen_q, rwrap_q);
                    rcnt_d   = rcnt_q + 8'd1;
                    rlast_d  = (rcnt_d == rlen_q);
                    rd_fetch = 1'b1;
                    rd_addr  = raddr_d;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // The RAM is read on the same edge that updates rdata_q. This makes
        // it a synchronous read, and a write on that edge is not yet visible.
        if (rd_fetch) begin
            if (in_range(rd_addr) && !rd_bad) begin
                rdata_d = mem[rd_addr[MEM_AW+1:2]];
                rresp_d = 2'b00;
            end else begin
                rdata_d = 32'd0;
                rresp_d = 2'b10;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_e    w_state_q, w_state_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic        wwrap_q, wwrap_d, werr_q, werr_d, mem_we, w_last_beat, w_beat_ok;

    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wwrap_d     = wwrap_q;
        werr_d      = werr_q;
        mem_we      = 1'b0;
        w_last_beat = (wcnt_q == wlen_q);
        w_beat_ok   = in_range(waddr_q) && !(wwrap_q && !len_ok(wlen_q));
        case (w_state_q)
            W_IDLE: if (awvalid) begin
                w_state_d = W_DATA;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                bid_d     = awid;
                waddr_d   = awaddr;
                wlen_d    = awlen;
                wcnt_d    = 8'd0;
                wwrap_d   = WRAP_EN && (awburst == 2'b10);
                werr_d    = wwrap_d && !len_ok(awlen);
            end
            W_DATA: if (wvalid) begin
                mem_we = w_beat_ok;
                // The error is sticky for the whole burst. The burst length
                // comes from awlen; wlast only serves as a consistency check.
                werr_d = werr_q || !w_beat_ok || (wlast != w_last_beat);
                if (w_last_beat) begin
                    w_state_d = W_RESP;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = werr_d ? 2'b10 : 2'b00;
                end else begin
                    waddr_d = next_addr(waddr_q, wlen_q, wwrap_q);
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            W_RESP: if (bready) begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[waddr_q[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_d_reset: begin end
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            raddr_q   <= 32'd0;
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            rwrap_q   <= 1'b0;
            rbad_q    <= 1'b0;
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= 2'b00;
            waddr_q   <= 32'd0;
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            wwrap_q   <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rwrap_q   <= rwrap_d;
            rbad_q    <= rbad_d;
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wwrap_q   <= wwrap_d;
            werr_q    <= werr_d;
        end
    end

    assign arready     = arready_q;
    assign rvalid      = rvalid_q;
    assign rlast       = rlast_q;
    assign rid         = rid_q;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign awready     = awready_q;
    assign wready      = wready_q;
    assign bvalid      = bvalid_q;
    assign bid         = bid_q;
    assign bresp       = bresp_q;
    assign dbg_r_state = r_state_q;
    assign dbg_w_state = w_state_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
module tb_axi_sram_responder;
  localparam logic [31:0] BASE = 32'h1fc0_0000;

  logic        clk, rst;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp, dbg_r_state, dbg_w_state;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  axi_sram_responder dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model [0:1023];
  logic [31:0] wd_v [16];
  logic [3:0]  ws_v [16];
  logic [31:0] last_rdata;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          e[4];
  } rd_vec_t;
  rd_vec_t rv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rv(input int i, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input int e0, input int e1, input int e2, input int e3);
    rv[i].id = id; rv[i].addr = addr; rv[i].len = len; rv[i].burst = burst;
    rv[i].e[0] = e0; rv[i].e[1] = e1; rv[i].e[2] = e2; rv[i].e[3] = e3;
  endtask

  // driver: one write burst (INCR); good_wlast=0 leaves wlast low on every beat
  task automatic axi_write(input string name, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input bit good_wlast, input logic [1:0] exp_resp);
    int n;
    logic [31:0] ba;
    @(negedge clk);
    check({name, "_awready"}, awready, 1);
    awid = id; awaddr = addr; awlen = len; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      if (!wready) begin check({name, "_wready_timeout"}, 0, 1); break; end
      wdata = wd_v[k]; wstrb = ws_v[k]; wlast = good_wlast ? (k == int'(len)) : 1'b0; wvalid = 1'b1;
      ba = addr + 32'(4 * k);
      if (ba[31:12] == BASE[31:12])
        for (int b = 0; b < 4; b++) if (ws_v[k][b]) model[ba[11:2]][8*b +: 8] = wd_v[k][8*b +: 8];
      @(posedge clk); @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check({name, "_bvalid"}, bvalid, 1);
    check({name, "_bid"}, bid, id);
    check({name, "_bresp"}, bresp, exp_resp);
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    check({name, "_bvalid_clr"}, bvalid, 0);
    check({name, "_awready_back"}, awready, 1);
  endtask

  // driver + compare: one read burst, rready held high; index <0 means SLVERR beat
  task automatic axi_read(input string name, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int e0, input int e1, input int e2, input int e3);
    int n;
    int idx [4];
    idx[0] = e0; idx[1] = e1; idx[2] = e2; idx[3] = e3;
    @(negedge clk);
    check({name, "_arready"}, arready, 1);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    check({name, "_first_rvalid"}, rvalid, 1);
    rready = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      check({name, $sformatf("_b%0d_rvalid", k)}, rvalid, 1);
      check({name, $sformatf("_b%0d_rdata", k)}, rdata, (idx[k] < 0) ? 32'd0 : model[idx[k]]);
      check({name, $sformatf("_b%0d_rresp", k)}, rresp, (idx[k] < 0) ? 2'b10 : 2'b00);
      check({name, $sformatf("_b%0d_rlast", k)}, rlast, k == int'(len));
      check({name, $sformatf("_b%0d_rid", k)}, rid, id);
      last_rdata = rdata;
      @(posedge clk); @(negedge clk);
    end
    rready = 1'b0;
    check({name, "_rvalid_clr"}, rvalid, 0);
    check({name, "_arready_back"}, arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rr [8];
    int beat;
    rst = 1'b1;
    arid = 0; araddr = 0; arlen = 0; arburst = 0; arsize = 3'd2; arlock = 0; arcache = 0; arprot = 0; arvalid = 0;
    awid = 0; awaddr = 0; awlen = 0; awburst = 0; awsize = 3'd2; awlock = 0; awcache = 0; awprot = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; rready = 0; bready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rstate", dbg_r_state, 0);
    check("rst_wstate", dbg_w_state, 0);

    // preload words 0..15
    for (int k = 0; k < 16; k++) begin wd_v[k] = 32'hC0DE_0000 + 32'(k); ws_v[k] = 4'hF; end
    axi_write("preload", 4'd1, BASE, 8'd15, 1'b1, 2'b00);
    // two-beat write with partial strobe
    wd_v[0] = 32'hAABB_CCDD; ws_v[0] = 4'hF;
    wd_v[1] = 32'h1122_3344; ws_v[1] = 4'b0011;
    axi_write("wr_strb", 4'd5, BASE, 8'd1, 1'b1, 2'b00);
    // out-of-range write must not touch word 0
    wd_v[0] = 32'hDEAD_BEEF; ws_v[0] = 4'hF;
    axi_write("wr_oor", 4'd7, 32'h0000_0000, 8'd0, 1'b1, 2'b10);
    // top word of the RAM
    wd_v[0] = 32'h7777_1023; ws_v[0] = 4'hF;
    axi_write("wr_top", 4'd2, BASE + 32'hFFC, 8'd0, 1'b1, 2'b00);

    // read vector table
    set_rv(0, 4'd3, BASE + 32'h10, 8'd3, 2'b01, 4, 5, 6, 7);
    set_rv(1, 4'd1, BASE, 8'd1, 2'b01, 0, 1, 0, 0);
`ifdef AXI_SRAM_WRAP_EN
    set_rv(2, 4'hF, BASE + 32'h18, 8'd3, 2'b10, 6, 7, 4, 5);
    set_rv(5, 4'd6, BASE + 32'h4, 8'd2, 2'b10, -1, -1, -1, 0);
`else
    set_rv(2, 4'hF, BASE + 32'h18, 8'd3, 2'b10, 6, 7, 8, 9);
    set_rv(5, 4'd6, BASE + 32'h4, 8'd2, 2'b10, 1, 2, 3, 0);
`endif
    set_rv(3, 4'd2, 32'h0000_0000, 8'd0, 2'b01, -1, 0, 0, 0);
    set_rv(4, 4'd4, BASE + 32'hFFC, 8'd1, 2'b01, 1023, -1, 0, 0);
    set_rv(6, 4'd9, BASE + 32'h20, 8'd0, 2'b11, 8, 0, 0, 0);
    set_rv(7, 4'hA, BASE + 32'h38, 8'd1, 2'b01, 14, 15, 0, 0);
    for (int i = 0; i < 8; i++)
      axi_read($sformatf("rd%0d", i), rv[i].id, rv[i].addr, rv[i].len, rv[i].burst,
               rv[i].e[0], rv[i].e[1], rv[i].e[2], rv[i].e[3]);

    // explicit values for the strobe write and the discarded write
    axi_read("rd_w1", 4'd0, BASE + 32'h4, 8'd0, 2'b01, 1, 0, 0, 0);
    check("w1_low_half", {16'd0, last_rdata[15:0]}, 32'h0000_3344);
    check("w1_high_half", {16'd0, last_rdata[31:16]}, 32'h0000_C0DE);
    axi_read("rd_w0", 4'd0, BASE, 8'd0, 2'b01, 0, 0, 0, 0);
    check("w0_unchanged", last_rdata, 32'hAABB_CCDD);

    // missing wlast: data still lands, response is SLVERR
    wd_v[0] = 32'h4040_0000; ws_v[0] = 4'hF;
    wd_v[1] = 32'h4040_0001; ws_v[1] = 4'hF;
    axi_write("wr_nolast", 4'd8, BASE + 32'h40, 8'd1, 1'b0, 2'b10);
    axi_read("rd_nolast", 4'd8, BASE + 32'h40, 8'd1, 2'b01, 16, 17, 0, 0);

    // rready stall 1-0-0-1 mid-burst
    rr[0] = 1; rr[1] = 0; rr[2] = 0; rr[3] = 1; rr[4] = 1; rr[5] = 1; rr[6] = 1; rr[7] = 1;
    @(negedge clk);
    arid = 4'd3; araddr = BASE + 32'h10; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    beat = 0;
    for (int c = 0; c < 8 && beat <= 3; c++) begin
      check($sformatf("stall_c%0d_rvalid", c), rvalid, 1);
      check($sformatf("stall_c%0d_rdata", c), rdata, model[4 + beat]);
      check($sformatf("stall_c%0d_rlast", c), rlast, beat == 3);
      rready = rr[c];
      @(posedge clk);
      if (rr[c]) beat++;
      @(negedge clk);
    end
    rready = 1'b0;
    check("stall_beats", beat, 4);
    check("stall_rvalid_clr", rvalid, 0);

    // early wvalid must wait for AW
    wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'h0; wlast = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("early_w_wready", wready, 0);
    end
    wvalid = 1'b0; wlast = 1'b0;

    // reset mid-burst
    @(negedge clk);
    arid = 4'd9; araddr = BASE; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_arready", arready, 1);
    check("mid_rst_rlast", rlast, 0);
    check("mid_rst_rid", rid, 0);
    check("mid_rst_rdata", rdata, 0);
    rst = 1'b0;
    axi_read("post_rst", 4'd3, BASE + 32'h10, 8'd3, 2'b01, 4, 5, 6, 7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
